mo_demont: RTL and testbench
============================

MO_DEMONT -- requirements
Module: mo_demont

Interface
REQ-001 SHALL have parameter WIDTH, default `DATA_WIDTH: operand width in bits.
REQ-002 SHALL have parameter Q, default `Q: odd modulus, 2 < Q < 2^WIDTH.
REQ-003 SHALL have parameter BITS_PER_CYCLE, default 1: reduction steps per clock; WIDTH must divide evenly by it.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  Montgomery-form value x, unsigned, 0..2^WIDTH-1.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  normal-form result, canonical 0..Q-1.
REQ-012 SHALL have port busy  output  1  high in RUN state.

Function
REQ-013 SHALL compute out_data = x * 2^(-WIDTH) mod Q, i.e. convert out of Montgomery domain, which undoes the 2^WIDTH factor the team's multiplier carries.
REQ-014 SHALL use iterative Montgomery halving:
- acc (WIDTH+1 bits, unsigned) loaded with x.
- Each step: if acc[0] then acc += Q; then acc >>= 1.
- Exactly WIDTH steps total.
REQ-015 SHALL perform a final correction after the last step: if acc >= Q, subtract Q. The result is then always < Q.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-018 SHALL accept input when in_valid and in_ready are both high at a rising edge. On acceptance: load acc, clear step counter, go to RUN.
REQ-019 SHALL, in RUN, perform BITS_PER_CYCLE steps per edge and increment the counter. After N = WIDTH/BITS_PER_CYCLE RUN edges: apply the correction, register out_data, set out_valid, go to DONE.
REQ-020 SHALL have latency of exactly N clock edges from the acceptance edge to the edge that raises out_valid.
REQ-021 SHALL, in DONE, hold out_valid=1 and out_data stable until out_ready=1.
- If out_ready=1 and in_valid=0: go to IDLE, clear out_valid.
- If out_ready=1 and in_valid=1: accept the new input on the same edge, go to RUN, clear out_valid. This gives back-to-back throughput of one result per N+1 cycles.
REQ-022 SHALL ignore in_valid and in_data while in RUN (in_ready=0); no input is lost or corrupted.
REQ-023 SHALL not change out_data except on the edge entering DONE.
REQ-024 SHALL keep acc at no more than WIDTH+1 bits, with no overflow for any input 0..2^WIDTH-1. Invariant: acc < 2^WIDTH + Q.
REQ-025 SHALL compute the same result for every BITS_PER_CYCLE value; only latency differs.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force: state=IDLE, out_valid=0, busy=0, out_data=0, acc=0, counter=0.
REQ-027 SHALL, when rst_n is asserted during RUN or DONE, abort the operation and discard any pending result. After release, in_ready=1 in the first cycle.
REQ-028 SHALL NOT accept an input on the first rising edge if rst_n deasserts coincident with it; acceptance is allowed from the next edge.

Verification (WIDTH=12, Q=3329, BITS_PER_CYCLE=1 unless stated)
REQ-029 SHALL cover: in_data=767 (Montgomery form of 1) accepted -> out_valid exactly 12 edges later, out_data=1.
REQ-030 SHALL cover: in_data=0 -> out_data=0; in_data=1 -> out_data=2704; in_data=3328 -> out_data=625; in_data=4095 -> out_data=626.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable. Then out_ready=1 with in_valid=1 (in_data=767) -> new input accepted on the same edge, next result 1 after 12 edges.
REQ-032 SHALL cover: in_valid toggled with varying data during RUN -> in_ready=0 throughout and the result is unaffected.
REQ-033 SHALL cover: rst_n pulsed low at step 6 of RUN -> out_valid=0 immediately, state IDLE, next transaction correct.
REQ-034 SHALL cover: BITS_PER_CYCLE=3 and =4, with random in_data against the reference model x*2704 mod 3329 -> all match, latency 4 and 3 edges respectively.

Source files
------------

// File: rtl/mo_demont.sv
// Converts a value out of the Montgomery domain: out = x * 2^-WIDTH mod Q.
// Uses iterative halving, BITS_PER_CYCLE steps per clock, then one conditional subtract.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif

module mo_demont #(
  parameter int unsigned WIDTH          = `DATA_WIDTH,
  parameter int unsigned Q              = `Q,
  // Must divide WIDTH evenly.
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned Steps = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  localparam logic [CntW-1:0]  LastCnt = CntW'(Steps - 1);
  localparam logic [WIDTH+1:0] QWide   = (WIDTH + 2)'(Q);
  localparam logic [WIDTH:0]   QAcc    = (WIDTH + 1)'(Q);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH:0]   acc_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH+1:0] walk;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] acc_final;
  logic             accept;

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == StRun);

  // acc < 2^WIDTH + Q, so acc + Q always fits in WIDTH+2 bits before the halving.
  always_comb begin
    walk = {1'b0, acc_q};
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (walk[0]) begin
        walk = walk + QWide;
      end
      walk = walk >> 1;
    end
    acc_step  = walk[WIDTH:0];
    acc_final = (acc_step >= QAcc) ? WIDTH'(acc_step - QAcc) : acc_step[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            acc_q   <= {1'b0, in_data};
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            out_data  <= acc_final;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Same-edge hand-off: consume the result and start the next operand.
            if (in_valid) begin
              acc_q   <= {1'b0, in_data};
              cnt_q   <= '0;
              state_q <= StRun;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mo_demont.sv
// Scoreboard bench for mo_demont: directed and random operands on a 1-step instance,
// random traffic with random back-pressure on 3- and 4-step instances.
module tb_mo_demont;

  localparam int unsigned QM = 3329;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_alt_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [11:0] in_data, out_data;
  logic        go = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int accq[$];

  always @(posedge clk) cyc <= cyc + 1;

  mo_demont #(.WIDTH(12), .Q(QM), .BITS_PER_CYCLE(1)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  // Result is the unique r in [0,Q) with r * 2^12 == x (mod Q).
  function automatic int ref_demont(input int x);
    for (int r = 0; r < int'(QM); r++) begin
      if (((r * 4096) % int'(QM)) == (x % int'(QM))) return r;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input int x, input int e);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = 12'(x);
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for operand %0d", x);
    end else begin
      exp_q.push_back(e);
      accq.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor for the 1-step instance.
  initial begin
    logic        pv;
    logic [11:0] pd;
    int          e, a;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (out_valid && !pv) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_result: got %0d expected no result", out_data);
          end else begin
            e = exp_q.pop_front();
            a = accq.pop_front();
            check("result", out_data, e);
            check("latency", cyc - a, 12);
          end
        end else if (out_valid && pv) begin
          check("hold_data", out_data, pd);
        end
        pd = out_data;
        pv = out_valid;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int unsigned Bpc = (g == 0) ? 3 : 4;
    localparam int          Lat = 12 / Bpc;

    logic        iv, ir, ov, ordy, bsy;
    logic [11:0] id, od;
    logic        done_b = 1'b0;
    int          eq[$];
    int          ec[$];

    mo_demont #(.WIDTH(12), .Q(QM), .BITS_PER_CYCLE(Bpc)) u_dut (
      .clk      (clk),
      .rst_n    (rst_alt_n),
      .in_valid (iv),
      .in_ready (ir),
      .in_data  (id),
      .out_valid(ov),
      .out_ready(ordy),
      .out_data (od),
      .busy     (bsy)
    );

    initial begin
      int x, t;
      iv   = 1'b0;
      id   = '0;
      ordy = 1'b1;
      wait (go);
      @(negedge clk);
      for (int k = 0; k < 25; k++) begin
        x  = int'($urandom_range(0, 4095));
        iv = 1'b1;
        id = 12'(x);
        t  = 0;
        #1;
        while (!ir && t < 100) begin
          @(negedge clk);
          ordy = 1'($urandom_range(0, 1));
          #1;
          t++;
        end
        checks++;
        if (!ir) begin
          errors++;
          $display("FAIL b%0d_send_timeout: in_ready got 0 expected 1", Bpc);
        end else begin
          eq.push_back(ref_demont(x));
          ec.push_back(cyc + 1);
        end
        @(negedge clk);
        iv   = 1'b0;
        ordy = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          ordy = 1'($urandom_range(0, 1));
        end
      end
      t = 0;
      while (eq.size() != 0 && t < 500) begin
        @(negedge clk);
        ordy = 1'b1;
        t++;
      end
      check((Bpc == 3) ? "b3_drain" : "b4_drain", eq.size(), 0);
      done_b = 1'b1;
    end

    initial begin
      logic        pv;
      logic [11:0] pd;
      int          e, a;
      pv = 1'b0;
      pd = '0;
      forever begin
        @(negedge clk);
        if (!rst_alt_n) begin
          pv = 1'b0;
        end else begin
          if (ov && !pv) begin
            if (eq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL b%0d_spurious: got %0d expected no result", Bpc, od);
            end else begin
              e = eq.pop_front();
              a = ec.pop_front();
              check((Bpc == 3) ? "b3_result" : "b4_result", od, e);
              check((Bpc == 3) ? "b3_latency" : "b4_latency", cyc - a, Lat);
              check((Bpc == 3) ? "b3_busy_done" : "b4_busy_done", bsy, 0);
            end
          end else if (ov && pv) begin
            check((Bpc == 3) ? "b3_hold" : "b4_hold", od, pd);
          end
          pd = od;
          pv = ov;
        end
      end
    end
  end

  initial begin
    int          vin[4];
    int          vexp[4];
    int          x, t;
    logic [11:0] hold;

    vin  = '{0, 1, 3328, 4095};
    vexp = '{0, 2704, 625, 626};

    rst_n     = 1'b1;
    rst_alt_n = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    rst_n     = 1'b0;
    rst_alt_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);

    repeat (3) @(negedge clk);
    #2;
    rst_n     = 1'b1;
    rst_alt_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    go = 1'b1;
    @(negedge clk);

    // Montgomery form of 1.
    send(767, 1);
    wait_idle();

    // Boundary operands, issued back-to-back.
    for (int i = 0; i < 4; i++) send(vin[i], vexp[i]);
    wait_idle();

    // Back-pressure in DONE, then same-edge hand-off to the next operand.
    out_ready = 1'b0;
    x = int'($urandom_range(0, 4095));
    send(x, ref_demont(x));
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_valid", out_valid, 1);
    hold = out_data;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, hold);
    end
    check("bp_in_ready_stalled", in_ready, 0);
    out_ready = 1'b1;
    send(767, 1);
    check("b2b_valid_cleared", out_valid, 0);
    check("b2b_busy", busy, 1);
    wait_idle();

    // Input activity during RUN must be ignored.
    x = int'($urandom_range(0, 4095));
    send(x, ref_demont(x));
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 12'($urandom_range(0, 4095));
      #1;
      check("run_in_ready", in_ready, 0);
      check("run_busy", busy, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset at step 6 of RUN aborts the operation.
    x = int'($urandom_range(0, 4095));
    send(x, ref_demont(x));
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_data", out_data, 0);
    exp_q.delete();
    accq.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("abort_release_in_ready", in_ready, 1);
    @(negedge clk);
    send(767, 1);
    wait_idle();

    // Random operands against the model.
    for (int k = 0; k < 20; k++) begin
      x = int'($urandom_range(0, 4095));
      send(x, ref_demont(x));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    t = 0;
    while (!(g_alt[0].done_b && g_alt[1].done_b) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!(g_alt[0].done_b && g_alt[1].done_b)) begin
      errors++;
      $display("FAIL alt_timeout: got unfinished streams expected both done");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
